regfile_sb: RTL and testbench

Parametrised register file with synchronous write, same-cycle write-to-read bypass, and a per-register busy scoreboard for the pipelined CPU datapath. It sits in the decode stage, between decode/issue and writeback. Issue allocates a destination register and marks it busy. Writeback writes the result and clears the busy bit. Decode reads operands together with their busy flags to drive stall logic.

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bundle of read, writeback, issue-allocate and flush signals between the
// decode stage (master) and the register file / scoreboard (slave).
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              rbusy1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              rbusy2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic              flush;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output raddr1, raddr2, we, waddr, wdata, alloc_en, alloc_addr, flush,
    input  rdata1, rbusy1, rdata2, rbusy2, busy_cnt
  );

  modport slave (
    input  raddr1, raddr2, we, waddr, wdata, alloc_en, alloc_addr, flush,
    output rdata1, rbusy1, rdata2, rbusy2, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-to-read bypass and a per-register
// busy scoreboard that issue sets, writeback clears and flush wipes.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busyCnt;

  logic              w_wrV;
  logic              w_alV;
  logic [DEPTH-1:0]  w_busyNext;
  logic [ADDR_W:0]   w_popCnt;

  // Reset gates the write so neither bypass nor the edge can commit data.
  assign w_wrV = bus.we & ~rst & ~(ZERO_EN && (bus.waddr == '0));
  assign w_alV = bus.alloc_en & ~bus.flush & ~(ZERO_EN && (bus.alloc_addr == '0));

  always_comb begin
    bus.rdata1 = r_mem[bus.raddr1];
    bus.rbusy1 = r_busy[bus.raddr1];
    if (rst || (ZERO_EN && (bus.raddr1 == '0))) begin
      bus.rdata1 = '0;
      bus.rbusy1 = 1'b0;
    end else if (w_wrV && (bus.waddr == bus.raddr1)) begin
      bus.rdata1 = bus.wdata;
      bus.rbusy1 = 1'b0;
    end
  end

  always_comb begin
    bus.rdata2 = r_mem[bus.raddr2];
    bus.rbusy2 = r_busy[bus.raddr2];
    if (rst || (ZERO_EN && (bus.raddr2 == '0))) begin
      bus.rdata2 = '0;
      bus.rbusy2 = 1'b0;
    end else if (w_wrV && (bus.waddr == bus.raddr2)) begin
      bus.rdata2 = bus.wdata;
      bus.rbusy2 = 1'b0;
    end
  end

  // Set after clear so a same-address allocate beats the writeback.
  always_comb begin
    w_busyNext = r_busy;
    if (bus.flush) begin
      w_busyNext = '0;
    end else begin
      if (w_wrV) w_busyNext[bus.waddr] = 1'b0;
      if (w_alV) w_busyNext[bus.alloc_addr] = 1'b1;
    end
  end

  always_comb begin
    w_popCnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_popCnt = w_popCnt + (ADDR_W+1)'(w_busyNext[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      if (w_wrV) r_mem[bus.waddr] <= bus.wdata;
      r_busy    <= w_busyNext;
      r_busyCnt <= w_popCnt;
    end
  end

  assign bus.busy_cnt = r_busyCnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb, checked against an
// array-based model of register contents and pending producers.
module tb_regfile_sb;
  logic clk;
  logic rst;
  int   nTests;
  int   nFail;

  logic [31:0] mMem [32];
  bit          mBusy [32];

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bif ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit modelWrV();
    return bif.we && !rst && (bif.waddr != 5'd0);
  endfunction

  function automatic logic [31:0] expData(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (modelWrV() && bif.waddr == a) return bif.wdata;
    return mMem[a];
  endfunction

  function automatic logic [31:0] expBusy(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (modelWrV() && bif.waddr == a) return 32'h0;
    return {31'h0, mBusy[a]};
  endfunction

  function automatic logic [31:0] busyCount();
    int c = 0;
    for (int i = 0; i < 32; i++) if (mBusy[i]) c++;
    return 32'(c);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 32; i++) begin
      mMem[i]  = 32'h0;
      mBusy[i] = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                               input bit ae, input logic [4:0] aa, input bit fl,
                               input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    bif.we         = we;
    bif.waddr      = wa;
    bif.wdata      = wd;
    bif.alloc_en   = ae;
    bif.alloc_addr = aa;
    bif.flush      = fl;
    bif.raddr1     = ra1;
    bif.raddr2     = ra2;
  endtask

  task automatic checkComb(input string tag);
    #1;
    checkOutput({tag, ".rdata1"}, bif.rdata1, expData(bif.raddr1));
    checkOutput({tag, ".rbusy1"}, 32'(bif.rbusy1), expBusy(bif.raddr1));
    checkOutput({tag, ".rdata2"}, bif.rdata2, expData(bif.raddr2));
    checkOutput({tag, ".rbusy2"}, 32'(bif.rbusy2), expBusy(bif.raddr2));
  endtask

  // Apply the scoreboard rules to the model at the edge, then check the count.
  task automatic tick(input string tag);
    bit wrV;
    bit alV;
    @(posedge clk);
    if (!rst) begin
      wrV = modelWrV();
      alV = bif.alloc_en && !bif.flush && (bif.alloc_addr != 5'd0);
      if (wrV) mMem[bif.waddr] = bif.wdata;
      if (bif.flush) begin
        for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
      end else if (wrV && alV && bif.waddr == bif.alloc_addr) begin
        mBusy[bif.waddr] = 1'b1;
      end else begin
        if (alV) mBusy[bif.alloc_addr] = 1'b1;
        if (wrV) mBusy[bif.waddr] = 1'b0;
      end
    end
    #1;
    checkOutput({tag, ".busy_cnt"}, 32'(bif.busy_cnt), busyCount());
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;
    rst    = 1'b1;
    modelReset();
    bif.we = 1'b0; bif.waddr = '0; bif.wdata = '0;
    bif.alloc_en = 1'b0; bif.alloc_addr = '0; bif.flush = 1'b0;
    bif.raddr1 = '0; bif.raddr2 = '0;

    // Power-on reset, then release between edges.
    applyStimulus(1, 5'd3, 32'hCAFE0003, 0, 0, 0, 5'd3, 5'd0);
    checkComb("por");
    checkOutput("por.busy_cnt", 32'(bif.busy_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Preload registers and a pending producer, then reset mid-operation.
    applyStimulus(1, 5'd10, 32'h10101010, 1, 5'd12, 0, 5'd10, 5'd12);
    tick("pre1");
    applyStimulus(1, 5'd11, 32'h11111111, 1, 5'd13, 0, 5'd10, 5'd12);
    checkComb("pre2");
    tick("pre2");
    applyStimulus(1, 5'd11, 32'h22222222, 1, 5'd14, 0, 5'd11, 5'd12);
    rst = 1'b1;
    modelReset();
    checkComb("rst");
    checkOutput("rst.busy_cnt", 32'(bif.busy_cnt), 32'h0);
    checkOutput("rst.rdata1", bif.rdata1, 32'h0);
    tick("rst");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd11, 5'd12);
    rst = 1'b0;
    checkComb("postrst");
    checkOutput("postrst.r11", bif.rdata1, 32'h0);

    // Register zero ignores writes and allocations.
    applyStimulus(1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, 5'd0);
    checkComb("zero.w");
    tick("zero.w");
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 0, 5'd0, 5'd0);
    checkComb("zero.a");
    tick("zero.a");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 5'd0);
    checkComb("zero.after");
    checkOutput("zero.rdata", bif.rdata1, 32'h0);
    checkOutput("zero.busy_cnt", 32'(bif.busy_cnt), 32'h0);

    // Same-cycle bypass on both ports, then stored value.
    applyStimulus(1, 5'd7, 32'h12345678, 0, 5'd0, 0, 5'd7, 5'd7);
    checkComb("byp");
    checkOutput("byp.rdata1", bif.rdata1, 32'h12345678);
    checkOutput("byp.rdata2", bif.rdata2, 32'h12345678);
    tick("byp");
    applyStimulus(0, 5'd7, 32'h0, 0, 5'd0, 0, 5'd7, 5'd7);
    checkComb("byp.mem");
    checkOutput("byp.mem.rdata2", bif.rdata2, 32'h12345678);

    // Allocate r5, then write it back.
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd5, 5'd7);
    tick("r5.alloc");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd5, 5'd7);
    checkComb("r5.busy");
    checkOutput("r5.rbusy1", 32'(bif.rbusy1), 32'h1);
    checkOutput("r5.cnt1", 32'(bif.busy_cnt), 32'h1);
    applyStimulus(1, 5'd5, 32'hA5A5A5A5, 0, 5'd0, 0, 5'd5, 5'd7);
    checkComb("r5.wb");
    checkOutput("r5.wb.rbusy1", 32'(bif.rbusy1), 32'h0);
    checkOutput("r5.wb.rdata1", bif.rdata1, 32'hA5A5A5A5);
    tick("r5.wb");
    checkOutput("r5.cnt0", 32'(bif.busy_cnt), 32'h0);

    // Allocate and write a busy r9 together: allocation wins.
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd9, 5'd9);
    tick("r9.alloc");
    applyStimulus(1, 5'd9, 32'h00000001, 1, 5'd9, 0, 5'd9, 5'd9);
    checkComb("r9.both");
    tick("r9.both");
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd9, 5'd9);
    checkComb("r9.after");
    checkOutput("r9.rdata", bif.rdata1, 32'h1);
    checkOutput("r9.rbusy", 32'(bif.rbusy2), 32'h1);
    checkOutput("r9.cnt", 32'(bif.busy_cnt), 32'h1);
    applyStimulus(1, 5'd9, 32'h00000002, 0, 5'd0, 0, 5'd9, 5'd9);
    tick("r9.clear");

    // Fill the scoreboard, then flush with a concurrent allocate and write.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(0, 5'd0, 32'h0, 1, 5'(i), 0, 5'(i), 5'd0);
      tick("fill");
    end
    checkOutput("fill.cnt31", 32'(bif.busy_cnt), 32'd31);
    applyStimulus(1, 5'd4, 32'h00000044, 1, 5'd3, 1, 5'd4, 5'd3);
    checkComb("flush.pre");
    tick("flush");
    checkOutput("flush.cnt0", 32'(bif.busy_cnt), 32'h0);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd4, 5'd3);
    checkComb("flush.after");
    checkOutput("flush.r4", bif.rdata1, 32'h44);
    checkOutput("flush.rbusy3", 32'(bif.rbusy2), 32'h0);

    // Random traffic against the model; issue never reallocates a busy register.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] aa;
      bit         ae;
      aa = 5'($urandom_range(0, 31));
      ae = ($urandom_range(0, 1) == 1) && !mBusy[aa];
      applyStimulus($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                    ae, aa, $urandom_range(0, 15) == 0,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) bif.waddr = bif.raddr1;
      if ($urandom_range(0, 7) == 0) bif.alloc_addr = bif.waddr;
      if (mBusy[bif.alloc_addr]) bif.alloc_en = 1'b0;
      checkComb("rand");
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
